// File: rtl/dm_store_pkg.sv
// dm_store_pkg: shared definitions for the dm_store data memory.
//   store_type_e : store width encoding (sw / sh / sb / illegal)
//   LOG_FMT      : format of the per-store log line printed when
//                  DM_STORE_LOG_EN is defined
package dm_store_pkg;

   typedef enum logic [1:0] {
      ST_SW  = 2'b00,
      ST_SH  = 2'b01,
      ST_SB  = 2'b10,
      ST_ILL = 2'b11
   } store_type_e;

   // pc, word-aligned byte address, merged word
   localparam string LOG_FMT = "@%h: *%h <= %h";

endpackage

// File: rtl/dm_store_lane_gen.sv
// store_lane_gen: combinational store-side packer.
// Narrows the rt value to the store width, replicates it across the byte
// lanes and produces lane enables plus an alignment/illegal-type fault.
// Ports:
//   store_type [1:0]  in   00 sw, 01 sh, 10 sb, 11 illegal
//   addr_lo    [1:0]  in   byte offset within the word
//   wdata      [31:0] in   rt value
//   we                in   store request
//   byte_en    [3:0]  out  lane enables; 0 when we=0 or faulting
//   lane_data  [31:0] out  store data replicated to every lane
//   fault             out  we=1 with a misaligned or illegal request
import dm_store_pkg::*;

module store_lane_gen (
   input  logic [1:0]  store_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [3:0]  byte_en,
   output logic [31:0] lane_data,
   output logic        fault
);

   logic [3:0] lanes;
   logic       legal;

   always_comb begin
      lanes     = '0;
      lane_data = '0;
      legal     = 1'b0;
      case (store_type_e'(store_type))
         ST_SW: begin
            lanes     = '1;
            lane_data = wdata;
            legal     = (addr_lo == 2'b00);
         end
         ST_SH: begin
            lanes     = addr_lo[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata[15:0]}};
            legal     = ~addr_lo[0];
         end
         ST_SB: begin
            lanes     = 4'b0001 << addr_lo;
            lane_data = {4{wdata[7:0]}};
            legal     = 1'b1;
         end
         default: begin
            lanes     = '0;
            lane_data = '0;
            legal     = 1'b0;
         end
      endcase

      byte_en = (we && legal) ? lanes : '0;
      fault   = we && !legal;
   end

endmodule

// File: rtl/dm_store.sv
// dm_store: MEM-stage data memory with store-side byte-lane packer.
// Optional feature macro: DM_STORE_LOG_EN (prints each committed store).
// Ports:
//   clk               in   clock, rising edge
//   reset             in   synchronous active-low reset; clears array + flags
//   we                in   store request
//   store_type [1:0]  in   00 sw, 01 sh, 10 sb, 11 illegal
//   addr       [31:0] in   byte address from the ALU
//   wdata      [31:0] in   rt value
//   pc         [31:0] in   PC of the instruction (logging only)
//   rdata      [31:0] out  combinational read of word at index(addr)
//   byte_en    [3:0]  out  lane enables of the current request
//   store_done        out  one-cycle pulse after a committed store
//   store_err         out  sticky fault flag, cleared only by reset
import dm_store_pkg::*;

module dm_store #(
   parameter int unsigned DEPTH_WORDS = 3072,
   parameter int unsigned IDX_WIDTH   = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  store_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   output logic [31:0] rdata,
   output logic [3:0]  byte_en,
   output logic        store_done,
   output logic        store_err
);

   logic [31:0]          mem_q [DEPTH_WORDS];
   logic                 store_done_q, store_done_d;
   logic                 store_err_q, store_err_d;

   logic [IDX_WIDTH-1:0] idx;
   logic                 in_range;
   logic [31:0]          old_word;
   logic [31:0]          merged;
   logic [31:0]          lane_data;
   logic                 fault;
   logic                 commit;
   logic                 unused_bits;

   store_lane_gen u_lane_gen (
      .store_type (store_type),
      .addr_lo    (addr[1:0]),
      .wdata      (wdata),
      .we         (we),
      .byte_en    (byte_en),
      .lane_data  (lane_data),
      .fault      (fault)
   );

   // Upper address bits are dropped so the index wraps; pc only feeds the log.
   assign unused_bits = ^{pc, addr[31:IDX_WIDTH+2]};

   assign idx      = addr[IDX_WIDTH+1:2];
   assign in_range = (32'(idx) < DEPTH_WORDS);

   always_comb begin
      old_word     = in_range ? mem_q[idx] : '0;
      merged       = old_word;
      for (int unsigned i = 0; i < 4; i++) begin
         if (byte_en[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
      end
      // An out-of-range store is legal: it pulses store_done but writes nothing.
      commit       = we && !fault;
      store_done_d = commit;
      store_err_d  = store_err_q | fault;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
         store_done_q <= 1'b0;
         store_err_q  <= 1'b0;
      end else begin
         store_done_q <= store_done_d;
         store_err_q  <= store_err_d;
         if (commit && in_range) mem_q[idx] <= merged;
`ifdef DM_STORE_LOG_EN
         if (commit) $display("%s", $sformatf(LOG_FMT, pc, {addr[31:2], 2'b00}, merged));
`endif
      end
   end

   assign rdata      = old_word;
   assign store_done = store_done_q;
   assign store_err  = store_err_q;

endmodule

// File: tb/tb_dm_store.sv
module tb_dm_store;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  store_type = 2'b00;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] pc = '0;
   logic [31:0] rdata;
   logic [3:0]  byte_en;
   logic        store_done;
   logic        store_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
      logic        done;
      logic        err;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mdl [int unsigned];
   logic        m_err = 1'b0;

   dm_store #(.DEPTH_WORDS(3072), .IDX_WIDTH(12)) dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .store_type (store_type),
      .addr       (addr),
      .wdata      (wdata),
      .pc         (pc),
      .rdata      (rdata),
      .byte_en    (byte_en),
      .store_done (store_done),
      .store_err  (store_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish before 2000000");
      $fatal(1);
   end

   function automatic logic mdl_in_range(input logic [31:0] a);
      return (a[13:2] < 12'd3072);
   endfunction

   function automatic logic [31:0] mdl_read(input logic [31:0] a);
      int unsigned k = a[13:2];
      if (!mdl_in_range(a)) return '0;
      return mdl.exists(k) ? mdl[k] : '0;
   endfunction

   task automatic lane_model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                             output logic [3:0] be, output logic flt, output logic [31:0] ld);
      be = 4'h0; flt = 1'b0; ld = '0;
      case (t)
         2'b00: begin be = 4'hF; ld = d; flt = (a[1:0] != 2'b00); end
         2'b01: begin be = a[1] ? 4'hC : 4'h3; ld = {d[15:0], d[15:0]}; flt = a[0]; end
         2'b10: begin
            case (a[1:0])
               2'd0: be = 4'h1;
               2'd1: be = 4'h2;
               2'd2: be = 4'h4;
               default: be = 4'h8;
            endcase
            ld = {4{d[7:0]}};
         end
         default: flt = 1'b1;
      endcase
   endtask

   // Drives one store, checks the in-cycle lane enables and old-word read,
   // queues the expected post-edge state and checks it after the edge.
   task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
      logic [3:0]  be;
      logic        flt;
      logic [31:0] ld, oldw, neww;
      exp_t        e;
      @(negedge clk);
      we = 1'b1; store_type = t; addr = a; wdata = d; pc = pc + 32'd4;
      lane_model(t, a, d, be, flt, ld);
      oldw = mdl_read(a);
      neww = oldw;
      for (int i = 0; i < 4; i++) if (be[i] && !flt) neww[8*i +: 8] = ld[8*i +: 8];
      #1;
      checks++;
      if (byte_en !== (flt ? 4'h0 : be)) begin
         errors++;
         $display("FAIL byte_en addr=%h type=%b: got %b expected %b", a, t, byte_en, flt ? 4'h0 : be);
      end
      checks++;
      if (rdata !== oldw) begin
         errors++;
         $display("FAIL old_word_during_store addr=%h: got %h expected %h", a, rdata, oldw);
      end
      e.addr = a;
      e.word = mdl_in_range(a) ? neww : 32'h0;
      e.done = !flt;
      e.err  = m_err | flt;
      if (!flt && mdl_in_range(a)) mdl[a[13:2]] = neww;
      m_err = m_err | flt;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      we = 1'b0;
      e = sbq.pop_front();
      addr = e.addr;
      #1;
      checks++;
      if (rdata !== e.word) begin
         errors++;
         $display("FAIL merged_word addr=%h: got %h expected %h", e.addr, rdata, e.word);
      end
      checks++;
      if (store_done !== e.done) begin
         errors++;
         $display("FAIL store_done addr=%h: got %b expected %b", e.addr, store_done, e.done);
      end
      checks++;
      if (store_err !== e.err) begin
         errors++;
         $display("FAIL store_err addr=%h: got %b expected %b", e.addr, store_err, e.err);
      end
   endtask

   task automatic idle_cycle;
      @(negedge clk);
      we = 1'b0;
      #1;
      checks++;
      if (byte_en !== 4'h0) begin
         errors++;
         $display("FAIL idle_byte_en: got %b expected 0000", byte_en);
      end
      @(posedge clk);
      #1;
      checks++;
      if (store_done !== 1'b0) begin
         errors++;
         $display("FAIL idle_store_done: got %b expected 0", store_done);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      we = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      mdl.delete();
      m_err = 1'b0;
      foreach (sbq[i]) ;
      addr = 32'h0; #1;
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata_0: got %h expected 0", rdata); end
      addr = 32'h2FFC; #1;
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata_2ffc: got %h expected 0", rdata); end
      checks++;
      if (store_err !== 1'b0) begin errors++; $display("FAIL reset_store_err: got %b expected 0", store_err); end
      checks++;
      if (store_done !== 1'b0) begin errors++; $display("FAIL reset_store_done: got %b expected 0", store_done); end
   endtask

   task automatic test_word_store;
      do_store(2'b00, 32'h10, 32'hDEADBEEF);
      checks++;
      if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_value: got %h expected deadbeef", rdata); end
      idle_cycle();
   endtask

   task automatic test_subword;
      do_store(2'b00, 32'h20, 32'h11223344);
      do_store(2'b10, 32'h21, 32'h000000AB);
      checks++;
      if (rdata !== 32'h1122AB44) begin errors++; $display("FAIL sb_merge: got %h expected 1122ab44", rdata); end
      do_store(2'b01, 32'h22, 32'h00005566);
      checks++;
      if (rdata !== 32'h5566AB44) begin errors++; $display("FAIL sh_merge: got %h expected 5566ab44", rdata); end
      // remaining lane patterns
      do_store(2'b10, 32'h43, 32'hFFFFFF9C);
      do_store(2'b01, 32'h40, 32'hABCD1234);
      do_store(2'b10, 32'h42, 32'h00000001);
   endtask

   task automatic test_misaligned;
      do_store(2'b00, 32'h22, 32'hFFFFFFFF);
      checks++;
      if (rdata !== 32'h5566AB44) begin errors++; $display("FAIL misaligned_unchanged: got %h expected 5566ab44", rdata); end
      do_store(2'b01, 32'h21, 32'h0000BBBB);
      do_store(2'b10, 32'h20, 32'h00000077);
      checks++;
      if (rdata !== 32'h5566AB77) begin errors++; $display("FAIL sb_after_fault: got %h expected 5566ab77", rdata); end
      checks++;
      if (store_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", store_err); end
   endtask

   task automatic test_back_to_back;
      do_store(2'b10, 32'h50, 32'h11);
      do_store(2'b10, 32'h51, 32'h22);
      do_store(2'b10, 32'h52, 32'h33);
      do_store(2'b10, 32'h53, 32'h44);
      checks++;
      if (rdata !== 32'h44332211) begin errors++; $display("FAIL back_to_back: got %h expected 44332211", rdata); end
   endtask

   task automatic test_illegal_and_reset;
      do_store(2'b11, 32'h24, 32'h12345678);
      checks++;
      if (store_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", store_err); end
      @(negedge clk);
      reset = 1'b0; we = 1'b1; store_type = 2'b00; addr = 32'h30; wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      reset = 1'b1; we = 1'b0;
      mdl.delete();
      m_err = 1'b0;
      #1;
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL reset_priority_0x30: got %h expected 0", rdata); end
      addr = 32'h20; #1;
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL reset_clear_0x20: got %h expected 0", rdata); end
      checks++;
      if (store_err !== 1'b0) begin errors++; $display("FAIL reset_err_clear: got %b expected 0", store_err); end
      checks++;
      if (store_done !== 1'b0) begin errors++; $display("FAIL reset_done_clear: got %b expected 0", store_done); end
   endtask

   task automatic test_wrap;
      do_store(2'b00, 32'h3000, 32'h99999999);
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL out_of_range_read: got %h expected 0", rdata); end
      do_store(2'b00, 32'h4010, 32'h0BADF00D);
      addr = 32'h10; #1;
      checks++;
      if (rdata !== 32'h0BADF00D) begin errors++; $display("FAIL wrap_alias_0x10: got %h expected 0badf00d", rdata); end
      do_store(2'b10, 32'hFFFF_2FFF, 32'h000000EE);
      addr = 32'h2FFC; #1;
      checks++;
      if (rdata !== 32'hEE000000) begin errors++; $display("FAIL last_word_sb: got %h expected ee000000", rdata); end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_subword();
      test_misaligned();
      test_back_to_back();
      test_illegal_and_reset();
      test_wrap();
      idle_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_store.md
Name: dm_store

Overview:
- Data memory with a store-side packer for the single-cycle MIPS CPU.
- It is the write-direction counterpart of the load-side immediate/data extender: it narrows the GPR value (rt) to word, halfword or byte and merges it into the addressed word with byte-lane enables.
- It holds the word array and provides a combinational word read port for the load path.
- It sits in the MEM stage, between the ALU address result and the register-file write-back mux.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words in the array.
- IDX_WIDTH, 12, word-index width; index = addr[IDX_WIDTH+1:2].

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- we  input  1  store request for this cycle.
- store_type  input  2  encoding: 00 sw, 01 sh, 10 sb, 11 illegal.
- addr  input  32  byte address from the ALU.
- wdata  input  32  rt value; only the low 8 or 16 bits are used for sb/sh.
- pc  input  32  PC of the current instruction; used for logging only.
- rdata  output  32  combinational read of the word at index(addr).
- byte_en  output  4  combinational lane enables for the current request; 0 when we=0 or the request is faulting.
- store_done  output  1  registered pulse, high for the one cycle after a committed store.
- store_err  output  1  registered sticky fault flag.

Behaviour:
Reset (reset=0 at a clk edge):
- All DEPTH_WORDS words are cleared to 0.
- store_done is cleared to 0; store_err is cleared to 0.
- Any we in the same cycle is ignored; reset has priority.

Index:
- Address bits above IDX_WIDTH+1 are ignored, so the index wraps modulo 2^IDX_WIDTH.
- An index >= DEPTH_WORDS reads 0 and its write is dropped. This is not a fault.

Lane rules (combinational):
- sw: lanes 1111; data = wdata. Legal only if addr[1:0]=00.
- sh: lanes 0011 if addr[1]=0, else 1100; data = {wdata[15:0], wdata[15:0]}. Legal only if addr[0]=0.
- sb: lane = one-hot of addr[1:0]; data = wdata[7:0] replicated 4 times. Always legal.
- store_type=11: illegal.

Commit:
- On a clk edge with reset=1, we=1 and a legal request, only the enabled byte lanes of mem[index] are updated. Other lanes are preserved.
- store_done is 1 in the following cycle, then returns to 0 unless another store commits.

Fault:
- A misaligned or illegal request with we=1 writes nothing.
- store_err is set at the edge and stays set until reset.
- store_done stays 0 for a faulting request.

Read timing:
- rdata is not registered.
- During a store cycle, rdata shows the old word; after the edge it shows the merged word.

Back-to-back stores:
- Stores on consecutive cycles to the same word accumulate correctly, since there is no buffering.

we=0:
- No state change, byte_en=0, store_done deasserts.

Optional Feature:
- Macro: DM_STORE_LOG_EN.
- Defined: each committed store prints once per edge, as "@%h: *%h <= %h" with pc, the word-aligned byte address, and the full merged word.
- Not defined: no simulation output; the logic is otherwise identical.

Decomposition:
- Shared package/header: the store_type constants ST_SW=2'b00, ST_SH=2'b01, ST_SB=2'b10, and the log format string.
- One natural sub-module: store_lane_gen, a combinational block.
  - Inputs: store_type, addr[1:0], wdata, we.
  - Outputs: byte_en, lane-replicated data, fault.
  - The dm_store top owns the array, the sticky error flag and store_done.

Test Plan:
- Reset then reads: hold reset=0 for 1 edge; read addr 0x0 and 0x2FFC -> rdata=0, store_err=0, store_done=0.
- Word store: sw addr=0x10, wdata=0xDEADBEEF -> next cycle rdata@0x10=0xDEADBEEF, store_done=1 for exactly one cycle.
- Sub-word merge:
  - Preload 0x11223344 at 0x20.
  - sb addr=0x21, wdata=0xAB -> 0x1122AB44.
  - Then sh addr=0x22, wdata=0x5566 -> 0x5566AB44.
- Misaligned store:
  - sw addr=0x22 with 0x5566AB44 stored -> word unchanged, byte_en=0, store_err=1 sticky, store_done=0.
  - A following legal sb still commits and store_err stays 1.
- Illegal type and reset priority:
  - store_type=11 -> store_err=1, no write.
  - Assert reset=0 together with we=1 sw addr=0x30 -> memory cleared, store_err=0, no write.
- Wrap/range: sw addr=0x3000 (index 3072) -> no write, no fault, rdata=0; addr 0x4010 aliases index 4 (0x10) and writes it.
